// File: rtl/free_run_down_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// zero_tick flags expiry combinationally in the cycle the counter sits at 0 while enabled.
module free_run_down_timer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         start,
  input  logic         stop,
  input  logic         en,
  input  logic         periodic,
  output logic [N-1:0] q,
  output logic         zero_tick,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    // NOTE: every next-state signal is defaulted first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (stop) begin
      state_d = IDLE;
    end else if (load) begin
      // Load owns the data path; a concurrent start still moves IDLE/DONE into RUN.
      reload_d = d;
      cnt_d    = d;
      if (state_q != RUN && start) state_d = RUN;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = reload_q;
          end
        end
        RUN: begin
          if (en) begin
            if (!cnt_zero)    cnt_d   = cnt_q - N'(1);
            else if (periodic) cnt_d  = reload_q;
            else               state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

  assign q         = cnt_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign zero_tick = (state_q == RUN) && en && cnt_zero;

endmodule
